// File: rtl/cpu_pkg.sv
// Shared CPU definitions: divider FSM state encodings and result constants.
package cpu_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE  = 2'd0,
    DIV_RUN   = 2'd1,
    DIV_FIXUP = 2'd2,
    DIV_DONE  = 2'd3
  } div_state_t;

  localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract the divisor.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor_mag,
  output logic [WIDTH-1:0] next_rem,
  output logic [WIDTH-1:0] next_quo
);

  logic [WIDTH-1:0] shifted_rem_s;
  logic [WIDTH:0]   trial_s;
  logic             fits_s;

  assign shifted_rem_s = {rem[WIDTH-2:0], quo[WIDTH-1]};
  assign trial_s       = {1'b0, shifted_rem_s} - {1'b0, divisor_mag};
  // A clear top bit means the trial difference is non-negative.
  assign fits_s        = ~trial_s[WIDTH];
  assign next_rem      = fits_s ? trial_s[WIDTH-1:0] : shifted_rem_s;
  assign next_quo      = {quo[WIDTH-2:0], fits_s};

endmodule

// File: rtl/div_unit.sv
// Multi-cycle signed restoring divider: quotient to zlow, remainder to zhigh.
module div_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int CNT_BITS = 6
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] zlow,
  output logic [WIDTH-1:0] zhigh
);

  div_state_t           state_r;
  logic [CNT_BITS-1:0]  cnt_r;
  logic [WIDTH-1:0]     rem_r;
  logic [WIDTH-1:0]     quo_r;
  logic [WIDTH-1:0]     dmag_r;
  logic                 sign_q_r;
  logic                 sign_rem_r;
  logic [WIDTH-1:0]     next_rem_s;
  logic [WIDTH-1:0]     next_quo_s;

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    negate = {WIDTH{1'b0}} - v;
  endfunction

  // Most negative value maps to itself, which is its correct unsigned magnitude.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    magnitude = v[WIDTH-1] ? negate(v) : v;
  endfunction

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem         (rem_r),
    .quo         (quo_r),
    .divisor_mag (dmag_r),
    .next_rem    (next_rem_s),
    .next_quo    (next_quo_s)
  );

  // Divider FSM, iteration datapath and registered outputs.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_r     <= DIV_IDLE;
      cnt_r       <= {CNT_BITS{1'b0}};
      rem_r       <= {WIDTH{1'b0}};
      quo_r       <= {WIDTH{1'b0}};
      dmag_r      <= {WIDTH{1'b0}};
      sign_q_r    <= 1'b0;
      sign_rem_r  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      zlow        <= {WIDTH{1'b0}};
      zhigh       <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        DIV_IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (divisor == {WIDTH{1'b0}}) begin
              zlow        <= DIV_ZERO_QUOT[WIDTH-1:0];
              zhigh       <= dividend;
              div_by_zero <= 1'b1;
              state_r     <= DIV_DONE;
            end else begin
              quo_r       <= magnitude(dividend);
              dmag_r      <= magnitude(divisor);
              sign_q_r    <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
              sign_rem_r  <= dividend[WIDTH-1];
              rem_r       <= {WIDTH{1'b0}};
              cnt_r       <= {CNT_BITS{1'b0}};
              div_by_zero <= 1'b0;
              busy        <= 1'b1;
              state_r     <= DIV_RUN;
            end
          end else begin
            state_r <= DIV_IDLE;
          end
        end
        DIV_RUN: begin
          rem_r <= next_rem_s;
          quo_r <= next_quo_s;
          cnt_r <= cnt_r + CNT_BITS'(1);
          if (cnt_r == CNT_BITS'(WIDTH - 1)) begin
            state_r <= DIV_FIXUP;
          end else begin
            state_r <= DIV_RUN;
          end
        end
        DIV_FIXUP: begin
          zlow    <= sign_q_r ? negate(quo_r) : quo_r;
          zhigh   <= sign_rem_r ? negate(rem_r) : rem_r;
          busy    <= 1'b0;
          state_r <= DIV_DONE;
        end
        DIV_DONE: begin
          done    <= 1'b1;
          state_r <= DIV_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_r <= DIV_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: signs, divide by zero, ignored start, clear.
module tb_div_unit;

  logic        clock;
  logic        clear;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] zlow;
  logic [31:0] zhigh;

  int errors;
  int checks;

  div_unit #(.WIDTH(32), .CNT_BITS(6)) dut (
    .clock       (clock),
    .clear       (clear),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .zlow        (zlow),
    .zhigh       (zhigh)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic test_reset();
    clear = 1'b1; start = 1'b0; dividend = 32'd0; divisor = 32'd0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({busy, done, div_by_zero} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got %b want 000", {busy, done, div_by_zero});
    end
    checks++;
    if ({zlow, zhigh} !== 64'd0) begin
      errors++;
      $display("FAIL reset_results: got %h/%h want 0/0", zlow, zhigh);
    end
    @(negedge clock);
    clear = 1'b0;
  endtask

  // Launches one divide; optional re-pulse of start at cycle glitch_at (0 = none).
  task automatic run_div(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_q, input logic [31:0] exp_r,
                         input logic exp_dz, input int exp_lat, input int exp_busy,
                         input int glitch_at);
    int lat;
    int busy_cnt;
    bit got;
    lat = 0; busy_cnt = 0; got = 1'b0;
    @(negedge clock);
    dividend = a; divisor = b; start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0; dividend = 32'hA5A5_5A5A; divisor = 32'h0000_0003;
    if (busy) busy_cnt++;
    for (int k = 1; k <= 60; k++) begin
      if (glitch_at != 0 && k == glitch_at) begin
        start = 1'b1; dividend = 32'd1; divisor = 32'd1;
      end else begin
        start = 1'b0;
      end
      @(posedge clock);
      #1;
      if (busy) busy_cnt++;
      if (done) begin
        lat = k; got = 1'b1;
        break;
      end
    end
    start = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s_timeout: no done within 60 cycles", name);
    end
    checks++;
    if (lat !== exp_lat) begin
      errors++;
      $display("FAIL %s_latency: got %0d want %0d", name, lat, exp_lat);
    end
    checks++;
    if (busy_cnt !== exp_busy) begin
      errors++;
      $display("FAIL %s_busy_cycles: got %0d want %0d", name, busy_cnt, exp_busy);
    end
    checks++;
    if (zlow !== exp_q) begin
      errors++;
      $display("FAIL %s_zlow: got %h want %h", name, zlow, exp_q);
    end
    checks++;
    if (zhigh !== exp_r) begin
      errors++;
      $display("FAIL %s_zhigh: got %h want %h", name, zhigh, exp_r);
    end
    checks++;
    if (div_by_zero !== exp_dz || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_flags: got dz=%b busy=%b want dz=%b busy=0", name, div_by_zero, busy, exp_dz);
    end
    @(posedge clock);
    #1;
    checks++;
    if (done !== 1'b0 || zlow !== exp_q || zhigh !== exp_r) begin
      errors++;
      $display("FAIL %s_after_done: got done=%b %h/%h want done=0 %h/%h", name, done, zlow, zhigh, exp_q, exp_r);
    end
  endtask

  task automatic test_signs();
    run_div("pos_pos", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34, 33, 0);
    run_div("neg_pos", 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 34, 33, 0);
    run_div("pos_neg", 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2, 1'b0, 34, 33, 0);
    run_div("neg_neg", 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 1'b0, 34, 33, 0);
  endtask

  task automatic test_div_zero();
    run_div("div0", 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1, 0, 0);
    run_div("after_div0", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 34, 33, 0);
  endtask

  task automatic test_boundary();
    run_div("overflow", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 34, 33, 0);
    run_div("max_pos", 32'h7FFF_FFFF, 32'd1, 32'h7FFF_FFFF, 32'd0, 1'b0, 34, 33, 0);
    run_div("min_by_min", 32'h8000_0000, 32'h8000_0000, 32'd1, 32'd0, 1'b0, 34, 33, 0);
  endtask

  task automatic test_ignored_start();
    run_div("restart_ignored", 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0, 34, 33, 10);
  endtask

  task automatic test_clear();
    bit seen;
    seen = 1'b0;
    @(negedge clock);
    dividend = 32'd1000; divisor = 32'd10; start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (15) @(posedge clock);
    #1;
    clear = 1'b1;
    #1;
    checks++;
    if ({busy, done, div_by_zero} !== 3'b000 || {zlow, zhigh} !== 64'd0) begin
      errors++;
      $display("FAIL clear_outputs: got busy=%b done=%b dz=%b %h/%h want all 0",
               busy, done, div_by_zero, zlow, zhigh);
    end
    @(negedge clock);
    clear = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clock);
      #1;
      if (done || busy) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL clear_no_done: got activity=%b want 0", seen);
    end
    run_div("after_clear", 32'd6, 32'd4, 32'd1, 32'd2, 1'b0, 34, 33, 0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_signs();
    test_div_zero();
    test_boundary();
    test_ignored_start();
    test_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
